sdram_port_arbiter: RTL and testbench

//  Two-port arbiter sharing the single SDRAM Avalon-MM slave between the LCD scan-out reader
//  (read-only) and the mandelbrot processor data port (read/write). Sits between both masters
//  and sdram_0. Scan-out gets priority when its line buffer runs low; otherwise round-robin.

---
 rtl/sdram_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM Avalon-MM slave between the LCD scan-out reader and the processor data port.
// Urgent LCD requests win; otherwise round-robin, with in-order read-data return via a tag FIFO.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_PENDING = 8,
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   lcd_address,
    input  logic                lcd_read,
    input  logic                lcd_urgent,
    output logic                lcd_waitrequest,
    output logic [DATA_W-1:0]   lcd_readdata,
    output logic                lcd_readdatavalid,
    input  logic [ADDR_W-1:0]   proc_address,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [DATA_W-1:0]   proc_writedata,
    input  logic [DATA_W/8-1:0] proc_byteenable,
    output logic                proc_waitrequest,
    output logic [DATA_W-1:0]   proc_readdata,
    output logic                proc_readdatavalid,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,
    output logic                err_orphan
);

    localparam int unsigned PTR_W  = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_PENDING + 1);
    localparam int unsigned BEAT_W = $clog2(MAX_HOLD + 1);

    localparam logic PORT_LCD  = 1'b0;
    localparam logic PORT_PROC = 1'b1;

    typedef enum logic [1:0] {IDLE, GNT_LCD, GNT_PROC} state_t;

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic [BEAT_W-1:0] beat_cnt;

    logic              tag_mem [MAX_PENDING];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  tag_cnt;

    logic lcd_req;
    logic proc_req;
    logic lcd_urgent_req;
    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic push;
    logic pop;
    logic head_tag;
    logic beat_last;

    assign lcd_req        = lcd_read;
    assign proc_req       = proc_read | proc_write;
    assign lcd_urgent_req = lcd_read & lcd_urgent;
    assign fifo_full      = (tag_cnt == CNT_W'(MAX_PENDING));
    assign fifo_empty     = (tag_cnt == '0);
    assign beat_last      = (beat_cnt == BEAT_W'(MAX_HOLD - 1));

    // Master-side mux of the granted port; reads are masked while the tag FIFO is full.
    always_comb begin
        m_address        = '0;
        m_read           = 1'b0;
        m_write          = 1'b0;
        m_writedata      = '0;
        m_byteenable     = '0;
        lcd_waitrequest  = 1'b1;
        proc_waitrequest = 1'b1;
        if (!reset) begin
            case (state)
                GNT_LCD: begin
                    m_address       = lcd_address;
                    m_read          = lcd_read & ~fifo_full;
                    m_byteenable    = '1;
                    lcd_waitrequest = m_waitrequest | (lcd_read & fifo_full);
                end
                GNT_PROC: begin
                    m_address        = proc_address;
                    m_read           = proc_read & ~fifo_full;
                    m_write          = proc_write;
                    m_writedata      = proc_writedata;
                    m_byteenable     = proc_byteenable;
                    proc_waitrequest = m_waitrequest | (proc_read & fifo_full);
                end
                default: ;
            endcase
        end
    end

    assign accept   = (m_read | m_write) & ~m_waitrequest;
    assign push     = m_read & ~m_waitrequest;
    assign pop      = m_readdatavalid & ~fifo_empty & ~reset;
    assign head_tag = tag_mem[rd_ptr];

    assign lcd_readdata       = m_readdata;
    assign proc_readdata      = m_readdata;
    assign lcd_readdatavalid  = pop & (head_tag == PORT_LCD);
    assign proc_readdatavalid = pop & (head_tag == PORT_PROC);

    // Grant selection and release.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (lcd_urgent_req)
                    state_next = GNT_LCD;
                else if (lcd_req && proc_req)
                    state_next = (last_grant == PORT_PROC) ? GNT_LCD : GNT_PROC;
                else if (lcd_req)
                    state_next = GNT_LCD;
                else if (proc_req)
                    state_next = GNT_PROC;
            end
            GNT_LCD: begin
                if (!lcd_req || (accept && beat_last))
                    state_next = IDLE;
            end
            GNT_PROC: begin
                if (!proc_req || (accept && beat_last) ||
                    (lcd_urgent_req && accept))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= PORT_PROC;
            beat_cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next != IDLE) begin
                last_grant <= (state_next == GNT_PROC) ? PORT_PROC : PORT_LCD;
                beat_cnt   <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end
        end
    end

    // Tag FIFO: records which port issued each accepted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tag_cnt    <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
                2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
                default: tag_cnt <= tag_cnt;
            endcase
            if (m_readdatavalid && fifo_empty)
                err_orphan <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= (state == GNT_PROC) ? PORT_PROC : PORT_LCD;
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: per-cycle vector table, a read-return scoreboard
// for alternating round-robin bursts, and hand sequences for stall, FIFO-full and reset cases.
module tb_sdram_port_arbiter;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] lcd_address;
    logic              lcd_read;
    logic              lcd_urgent;
    logic              lcd_waitrequest;
    logic [DATA_W-1:0] lcd_readdata;
    logic              lcd_readdatavalid;
    logic [ADDR_W-1:0] proc_address;
    logic              proc_read;
    logic              proc_write;
    logic [DATA_W-1:0] proc_writedata;
    logic [BE_W-1:0]   proc_byteenable;
    logic              proc_waitrequest;
    logic [DATA_W-1:0] proc_readdata;
    logic              proc_readdatavalid;
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic [BE_W-1:0]   m_byteenable;
    logic              m_waitrequest;
    logic [DATA_W-1:0] m_readdata;
    logic              m_readdatavalid;
    logic              err_orphan;

    sdram_port_arbiter dut (
        .clk                (clk),
        .reset              (reset),
        .lcd_address        (lcd_address),
        .lcd_read           (lcd_read),
        .lcd_urgent         (lcd_urgent),
        .lcd_waitrequest    (lcd_waitrequest),
        .lcd_readdata       (lcd_readdata),
        .lcd_readdatavalid  (lcd_readdatavalid),
        .proc_address       (proc_address),
        .proc_read          (proc_read),
        .proc_write         (proc_write),
        .proc_writedata     (proc_writedata),
        .proc_byteenable    (proc_byteenable),
        .proc_waitrequest   (proc_waitrequest),
        .proc_readdata      (proc_readdata),
        .proc_readdatavalid (proc_readdatavalid),
        .m_address          (m_address),
        .m_read             (m_read),
        .m_write            (m_write),
        .m_writedata        (m_writedata),
        .m_byteenable       (m_byteenable),
        .m_waitrequest      (m_waitrequest),
        .m_readdata         (m_readdata),
        .m_readdatavalid    (m_readdatavalid),
        .err_orphan         (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in : {reset, lcd_read, lcd_urgent, proc_read, proc_write, m_waitrequest, m_readdatavalid}
    // exp: {m_read, m_write, lcd_wr, proc_wr, lcd_rdv, proc_rdv, err_orphan}
    typedef struct packed {
        logic [6:0] in;
        logic [6:0] ex;
    } vec_t;

    typedef struct packed {
        logic              port;
        logic [DATA_W-1:0] data;
    } rd_exp_t;

    int n_checks = 0;
    int n_errors = 0;
    rd_exp_t sb_q[$];
    vec_t vecs [27];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bus(input string nm, input logic mr, input logic mw, input logic lwr,
                       input logic pwr);
        chk({nm, " m_read"}, 64'(m_read), 64'(mr));
        chk({nm, " m_write"}, 64'(m_write), 64'(mw));
        chk({nm, " lcd_waitrequest"}, 64'(lcd_waitrequest), 64'(lwr));
        chk({nm, " proc_waitrequest"}, 64'(proc_waitrequest), 64'(pwr));
    endtask

    task automatic rdv(input string nm, input logic lv, input logic pv);
        chk({nm, " lcd_readdatavalid"}, 64'(lcd_readdatavalid), 64'(lv));
        chk({nm, " proc_readdatavalid"}, 64'(proc_readdatavalid), 64'(pv));
    endtask

    task automatic clear_inputs;
        lcd_address = '0; lcd_read = 1'b0; lcd_urgent = 1'b0;
        proc_address = '0; proc_read = 1'b0; proc_write = 1'b0;
        proc_writedata = '0; proc_byteenable = '0;
        m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ 32'h5A5A_0000;
    endfunction

    // 0: no grant, 1: LCD, 2: proc, for cycle k of the continuous two-port read run.
    function automatic int exp_grant(input int k);
        int ph;
        if (k == 0) return 0;
        ph = (k - 1) % 34;
        if (ph < 16) return 1;
        if (ph == 16 || ph == 33) return 0;
        return 2;
    endfunction

    initial begin
        reset = 1'b1;
        clear_inputs();

        vecs[0]  = '{7'b1000100, 7'b0011000};
        vecs[1]  = '{7'b0000100, 7'b0011000};
        vecs[2]  = '{7'b0000100, 7'b0110000};
        vecs[3]  = '{7'b0000100, 7'b0110000};
        vecs[4]  = '{7'b0000100, 7'b0110000};
        vecs[5]  = '{7'b0000100, 7'b0110000};
        vecs[6]  = '{7'b0000000, 7'b0010000};
        vecs[7]  = '{7'b0000000, 7'b0011000};
        vecs[8]  = '{7'b0000001, 7'b0011000};
        vecs[9]  = '{7'b0000000, 7'b0011001};
        vecs[10] = '{7'b0100000, 7'b0011001};
        vecs[11] = '{7'b0100000, 7'b1001001};
        vecs[12] = '{7'b0000001, 7'b0001101};
        vecs[13] = '{7'b1100000, 7'b0011001};
        vecs[14] = '{7'b0000000, 7'b0011000};
        vecs[15] = '{7'b0100000, 7'b0011000};
        vecs[16] = '{7'b0100000, 7'b1001000};
        vecs[17] = '{7'b0000000, 7'b0001000};
        vecs[18] = '{7'b0101000, 7'b0011000};
        vecs[19] = '{7'b0111000, 7'b1010000};
        vecs[20] = '{7'b0111000, 7'b0011000};
        vecs[21] = '{7'b0111000, 7'b1001000};
        vecs[22] = '{7'b0000001, 7'b0001100};
        vecs[23] = '{7'b0000001, 7'b0011010};
        vecs[24] = '{7'b0000001, 7'b0011100};
        vecs[25] = '{7'b0000001, 7'b0011000};
        vecs[26] = '{7'b0000000, 7'b0011001};

        @(posedge clk);
        #1;

        // Vector table: proc write burst, orphan flag, urgency and round-robin, tag routing.
        for (int i = 0; i < 27; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            {reset, lcd_read, lcd_urgent, proc_read, proc_write, m_waitrequest,
             m_readdatavalid} = vecs[i].in;
            lcd_address     = ADDR_W'(32'h100 + 32'(i));
            proc_address    = ADDR_W'(32'h300 + 32'(i));
            proc_writedata  = 32'hD000_0000 + 32'(i);
            proc_byteenable = BE_W'(i);
            m_readdata      = 32'hCAFE_0000 + 32'(i);
            @(negedge clk);
            bus(nm, vecs[i].ex[6], vecs[i].ex[5], vecs[i].ex[4], vecs[i].ex[3]);
            rdv(nm, vecs[i].ex[2], vecs[i].ex[1]);
            chk({nm, " err_orphan"}, 64'(err_orphan), 64'(vecs[i].ex[0]));
            if (vecs[i].ex[5]) begin
                chk({nm, " wr addr"}, 64'(m_address), 64'(proc_address));
                chk({nm, " wr data"}, 64'(m_writedata), 64'(proc_writedata));
                chk({nm, " wr be"}, 64'(m_byteenable), 64'(proc_byteenable));
            end
            if (vecs[i].ex[6] && !vecs[i].ex[4]) begin
                chk({nm, " lcd addr"}, 64'(m_address), 64'(lcd_address));
                chk({nm, " lcd wdata"}, 64'(m_writedata), 64'(0));
                chk({nm, " lcd be"}, 64'(m_byteenable), 64'(4'hF));
            end
            if (vecs[i].ex[2] || vecs[i].ex[1])
                chk({nm, " rdata"}, 64'(vecs[i].ex[2] ? lcd_readdata : proc_readdata),
                    64'(m_readdata));
            @(posedge clk);
            #1;
        end

        // Continuous reads from both ports: alternating MAX_HOLD grants, scoreboarded returns.
        begin
            logic [ADDR_W-1:0] lcd_a;
            logic [ADDR_W-1:0] proc_a;
            logic              p0v, p1v;
            logic [DATA_W-1:0] p0d, p1d;
            do_reset();
            lcd_a = ADDR_W'(32'h1000);
            proc_a = ADDR_W'(32'h2000);
            p0v = 1'b0; p1v = 1'b0; p0d = '0; p1d = '0;
            for (int k = 0; k < 80; k++) begin
                int g;
                logic nv;
                logic [DATA_W-1:0] nd;
                lcd_read = (k < 70);
                proc_read = (k < 70);
                lcd_address = lcd_a;
                proc_address = proc_a;
                m_readdatavalid = p1v;
                m_readdata = p1d;
                @(negedge clk);
                if (k < 70) begin
                    g = exp_grant(k);
                    chk($sformatf("rr%0d m_read", k), 64'(m_read), 64'(g != 0));
                    chk($sformatf("rr%0d lcd_wr", k), 64'(lcd_waitrequest), 64'(g != 1));
                    chk($sformatf("rr%0d proc_wr", k), 64'(proc_waitrequest), 64'(g != 2));
                    if (g == 1) sb_q.push_back('{1'b0, rd_data(lcd_a)});
                    if (g == 2) sb_q.push_back('{1'b1, rd_data(proc_a)});
                end
                chk($sformatf("rr%0d fwd", k), 64'(lcd_readdatavalid | proc_readdatavalid),
                    64'(m_readdatavalid));
                chk($sformatf("rr%0d both_rdv", k),
                    64'(lcd_readdatavalid & proc_readdatavalid), 64'(0));
                if (lcd_readdatavalid || proc_readdatavalid) begin
                    if (sb_q.size() == 0) begin
                        chk($sformatf("rr%0d sb_empty", k), 64'(1), 64'(0));
                    end else begin
                        rd_exp_t e;
                        e = sb_q.pop_front();
                        chk($sformatf("rr%0d port", k), 64'(proc_readdatavalid), 64'(e.port));
                        chk($sformatf("rr%0d data", k),
                            64'(proc_readdatavalid ? proc_readdata : lcd_readdata),
                            64'(e.data));
                    end
                end
                nv = m_read & ~m_waitrequest;
                nd = rd_data(m_address);
                if (lcd_read && !lcd_waitrequest) lcd_a = lcd_a + ADDR_W'(1);
                if (proc_read && !proc_waitrequest) proc_a = proc_a + ADDR_W'(1);
                p1v = p0v; p1d = p0d;
                p0v = nv; p0d = nd;
                @(posedge clk);
                #1;
            end
            chk("rr sb drained", 64'(sb_q.size()), 64'(0));
        end

        // Proc write stalled by the slave while LCD turns urgent.
        begin
            logic [ADDR_W-1:0] pa;
            int n_acc;
            do_reset();
            pa = ADDR_W'(32'h40);
            n_acc = 0;
            proc_write = 1'b1;
            proc_writedata = 32'h1234_5678;
            proc_byteenable = 4'hF;
            for (int k = 0; k < 8; k++) begin
                string nm;
                nm = $sformatf("stall%0d", k);
                m_waitrequest = (k == 3 || k == 4);
                lcd_read = (k >= 3);
                lcd_urgent = (k >= 3);
                proc_address = pa;
                @(negedge clk);
                case (k)
                    0:       bus(nm, 1'b0, 1'b0, 1'b1, 1'b1);
                    1, 2, 5: bus(nm, 1'b0, 1'b1, 1'b1, 1'b0);
                    3, 4:    bus(nm, 1'b0, 1'b1, 1'b1, 1'b1);
                    6:       bus(nm, 1'b0, 1'b0, 1'b1, 1'b1);
                    default: bus(nm, 1'b1, 1'b0, 1'b0, 1'b1);
                endcase
                if (k == 3 || k == 4)
                    chk({nm, " held addr"}, 64'(m_address), 64'(32'h42));
                if (m_write && !m_waitrequest) begin
                    chk({nm, " beat addr"}, 64'(m_address), 64'(32'h40 + 32'(n_acc)));
                    n_acc++;
                end
                if (proc_write && !proc_waitrequest) pa = pa + ADDR_W'(1);
                @(posedge clk);
                #1;
            end
            chk("stall beats", 64'(n_acc), 64'(3));
        end

        // Tag FIFO fills at MAX_PENDING; one return frees a slot.
        do_reset();
        proc_read = 1'b1;
        for (int k = 0; k < 13; k++) begin
            string nm;
            nm = $sformatf("full%0d", k);
            proc_address = ADDR_W'(32'h500 + 32'(k));
            m_readdatavalid = (k == 11);
            @(negedge clk);
            if (k == 0 || (k >= 9 && k <= 11))
                bus(nm, 1'b0, 1'b0, 1'b1, 1'b1);
            else
                bus(nm, 1'b1, 1'b0, 1'b1, 1'b0);
            rdv(nm, 1'b0, k == 11);
            @(posedge clk);
            #1;
        end

        // Reset mid-burst with reads pending, then a fresh LCD grant.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            string nm;
            nm = $sformatf("rst%0d", k);
            reset = (k == 4);
            lcd_read = !(k == 5 || k == 8);
            lcd_address = ADDR_W'(32'h700 + 32'(k));
            m_readdatavalid = (k == 4 || k == 5 || k == 8);
            @(negedge clk);
            case (k)
                1, 2, 3, 7: bus(nm, 1'b1, 1'b0, 1'b0, 1'b1);
                8:          bus(nm, 1'b0, 1'b0, 1'b0, 1'b1);
                default:    bus(nm, 1'b0, 1'b0, 1'b1, 1'b1);
            endcase
            rdv(nm, k == 8, 1'b0);
            if (k >= 5)
                chk({nm, " err_orphan"}, 64'(err_orphan), 64'(k >= 6));
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
